// File: rtl/sequencer_pkg.sv
// Shared command encodings and default address width for the program sequencer.
// Pure declarations: no logic, no latency, no flow control.
package sequencer_pkg;

  localparam int DEFAULT_WORD_SIZE = 8;

  localparam logic [2:0] HOLD   = 3'd0;
  localparam logic [2:0] STEP   = 3'd1;
  localparam logic [2:0] BRANCH = 3'd2;
  localparam logic [2:0] JUMP   = 3'd3;
  localparam logic [2:0] CALL   = 3'd4;
  localparam logic [2:0] RETURN = 3'd5;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; push/pop take effect on the next rising edge (1 cycle).
// No backpressure: a push when full or a pop when empty is silently dropped.
module return_stack #(
  parameter int WORD_SIZE   = 8,
  parameter int STACK_DEPTH = 4,
  parameter int CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_enable,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] push_data,
  output logic [WORD_SIZE-1:0] top,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WORD_SIZE-1:0] mem_q [STACK_DEPTH];
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        top_idx;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count_q == CW'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;
  assign wr_idx  = AW'(count_q);
  assign top_idx = AW'(count_q - CW'(1));

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is never cleared; only count decides which slots are live.
  always_ff @(posedge clock) begin
    if (reset_enable) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_idx] <= push_data;
      end
    end
  end

  assign top   = empty ? '0 : mem_q[top_idx];
  assign count = count_q;

endmodule

// File: rtl/program_sequencer.sv
// Program counter with step/branch/jump/call/return; every command lands after one edge.
// No backpressure: one command per cycle, stack misuse sets a sticky error instead.
module program_sequencer
  import sequencer_pkg::*;
#(
  parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
  parameter int STACK_DEPTH = 4,
  parameter int STEP_SIZE   = 1
) (
  input  logic                               clock,
  input  logic                               reset_enable,
  input  logic [2:0]                         command,
  input  logic [WORD_SIZE-1:0]               value,
  input  logic                               clear_error,
  output logic [WORD_SIZE-1:0]               pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_empty,
  output logic                               stack_full,
  output logic [WORD_SIZE-1:0]               stack_top,
  output logic                               stack_error
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam logic [WORD_SIZE-1:0] STEP_W = WORD_SIZE'(STEP_SIZE);

  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] pc_d;
  logic                 err_q;
  logic                 err_d;
  logic                 push;
  logic                 pop;
  logic [WORD_SIZE-1:0] push_data;

  assign push_data = pc_q + STEP_W;

  // A fresh error outranks clear_error, so the set below overrides the clear.
  always_comb begin
    pc_d  = pc_q;
    err_d = clear_error ? 1'b0 : err_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (command)
      STEP:   pc_d = pc_q + STEP_W;
      BRANCH: pc_d = pc_q + value;
      JUMP:   pc_d = value;
      CALL: begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = value;
        end
      end
      RETURN: begin
        if (stack_empty) begin
          err_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = stack_top;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_enable) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  return_stack #(
    .WORD_SIZE  (WORD_SIZE),
    .STACK_DEPTH(STACK_DEPTH),
    .CW         (CW)
  ) u_return_stack (
    .clock       (clock),
    .reset_enable(reset_enable),
    .push        (push),
    .pop         (pop),
    .push_data   (push_data),
    .top         (stack_top),
    .count       (stack_count),
    .full        (stack_full),
    .empty       (stack_empty)
  );

  assign pc          = pc_q;
  assign stack_error = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed scenarios plus random commands checked against a queue-based model.
module tb_program_sequencer;
  import sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset_enable;
  logic [2:0] command;
  logic [7:0] value;
  logic       clear_error;
  logic [7:0] pc;
  logic [2:0] stack_count;
  logic       stack_empty;
  logic       stack_full;
  logic [7:0] stack_top;
  logic       stack_error;

  always #5 clock = ~clock;

  program_sequencer #(
    .WORD_SIZE  (8),
    .STACK_DEPTH(4),
    .STEP_SIZE  (1)
  ) dut (
    .clock       (clock),
    .reset_enable(reset_enable),
    .command     (command),
    .value       (value),
    .clear_error (clear_error),
    .pc          (pc),
    .stack_count (stack_count),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_top   (stack_top),
    .stack_error (stack_error)
  );

  logic [7:0] m_pc;
  logic [7:0] m_stk [$];
  logic       m_err;
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_top;
    exp_top = (m_stk.size() == 0) ? 8'h00 : m_stk[m_stk.size()-1];
    chk({tag, ".pc"},    32'(pc),          32'(m_pc));
    chk({tag, ".count"}, 32'(stack_count), 32'(m_stk.size()));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
    chk({tag, ".full"},  32'(stack_full),  32'(m_stk.size() == 4));
    chk({tag, ".top"},   32'(stack_top),   32'(exp_top));
    chk({tag, ".err"},   32'(stack_error), 32'(m_err));
  endtask

  task automatic apply(input logic [2:0] cmd, input logic [7:0] val,
                       input logic clr, input logic rst, input string tag);
    command      = cmd;
    value        = val;
    clear_error  = clr;
    reset_enable = rst;
    @(posedge clock);
    if (rst) begin
      m_pc  = 8'h00;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      if (clr) m_err = 1'b0;
      case (cmd)
        3'd1: m_pc = m_pc + 8'd1;
        3'd2: m_pc = m_pc + val;
        3'd3: m_pc = val;
        3'd4: if (m_stk.size() == 4) m_err = 1'b1;
              else begin m_stk.push_back(m_pc + 8'd1); m_pc = val; end
        3'd5: if (m_stk.size() == 0) m_err = 1'b1;
              else m_pc = m_stk.pop_back();
        default: ;
      endcase
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    reset_enable = 1'b1;
    command      = HOLD;
    value        = 8'h00;
    clear_error  = 1'b0;
    m_pc  = 8'h00;
    m_err = 1'b0;

    apply(HOLD, 8'h00, 1'b0, 1'b1, "reset");
    chk("reset.pc_const", 32'(pc), 32'h0);
    chk("reset.empty_const", 32'(stack_empty), 32'h1);

    apply(STEP, 8'h00, 1'b0, 1'b0, "step1");
    apply(STEP, 8'h00, 1'b0, 1'b0, "step2");
    apply(STEP, 8'h00, 1'b0, 1'b0, "step3");
    chk("step3.pc_const", 32'(pc), 32'h3);
    apply(JUMP, 8'hFF, 1'b0, 1'b0, "jump_ff");
    apply(STEP, 8'h00, 1'b0, 1'b0, "step_wrap");
    chk("step_wrap.pc_const", 32'(pc), 32'h0);

    apply(JUMP, 8'h10, 1'b0, 1'b0, "jump_10");
    apply(BRANCH, 8'hFC, 1'b0, 1'b0, "branch_m4");
    chk("branch_m4.pc_const", 32'(pc), 32'h0C);
    apply(BRANCH, 8'h05, 1'b0, 1'b0, "branch_p5");
    chk("branch_p5.pc_const", 32'(pc), 32'h11);
    apply(JUMP, 8'h02, 1'b0, 1'b0, "jump_02");
    apply(BRANCH, 8'hFC, 1'b0, 1'b0, "branch_wrap");
    chk("branch_wrap.pc_const", 32'(pc), 32'hFE);

    apply(JUMP, 8'h20, 1'b0, 1'b0, "jump_20");
    apply(CALL, 8'h40, 1'b0, 1'b0, "call_40");
    chk("call_40.top_const", 32'(stack_top), 32'h21);
    apply(RETURN, 8'h00, 1'b0, 1'b0, "ret_21");
    chk("ret_21.pc_const", 32'(pc), 32'h21);

    apply(CALL, 8'h50, 1'b0, 1'b0, "call_50");
    apply(CALL, 8'h60, 1'b0, 1'b0, "call_60");
    apply(CALL, 8'h70, 1'b0, 1'b0, "call_70");
    apply(CALL, 8'h80, 1'b0, 1'b0, "call_80");
    chk("call_80.full_const", 32'(stack_full), 32'h1);
    apply(CALL, 8'h90, 1'b0, 1'b0, "call_overflow");
    chk("overflow.pc_const", 32'(pc), 32'h80);
    chk("overflow.err_const", 32'(stack_error), 32'h1);
    apply(RETURN, 8'h00, 1'b0, 1'b0, "ret_a");
    chk("ret_a.pc_const", 32'(pc), 32'h71);
    apply(RETURN, 8'h00, 1'b0, 1'b0, "ret_b");
    apply(RETURN, 8'h00, 1'b0, 1'b0, "ret_c");
    apply(RETURN, 8'h00, 1'b0, 1'b0, "ret_d");
    chk("ret_d.pc_const", 32'(pc), 32'h22);

    apply(HOLD, 8'h00, 1'b1, 1'b0, "clear_pre");
    apply(RETURN, 8'h00, 1'b0, 1'b0, "underflow");
    chk("underflow.err_const", 32'(stack_error), 32'h1);
    apply(HOLD, 8'h00, 1'b1, 1'b0, "clear_alone");
    chk("clear_alone.err_const", 32'(stack_error), 32'h0);
    apply(RETURN, 8'h00, 1'b1, 1'b0, "clear_vs_err");
    chk("clear_vs_err.err_const", 32'(stack_error), 32'h1);

    apply(CALL, 8'h10, 1'b0, 1'b0, "pre_rst_call1");
    apply(CALL, 8'h33, 1'b0, 1'b0, "pre_rst_call2");
    chk("pre_rst.count_const", 32'(stack_count), 32'h2);
    apply(CALL, 8'h44, 1'b0, 1'b1, "reset_mid");
    chk("reset_mid.pc_const", 32'(pc), 32'h0);
    chk("reset_mid.count_const", 32'(stack_count), 32'h0);
    chk("reset_mid.err_const", 32'(stack_error), 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] rc;
      logic [7:0] rv;
      logic       rclr;
      logic       rrst;
      rc   = 3'($urandom_range(0, 7));
      rv   = 8'($urandom);
      rclr = ($urandom_range(0, 7) == 0);
      rrst = ($urandom_range(0, 49) == 0);
      apply(rc, rv, rclr, rrst, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised successor to the core's program counter. Holds the current instruction address and, each cycle, applies one command: hold, step, signed relative branch, absolute jump, subroutine call or return. Calls and returns use an internal return-address stack of configurable depth. Sits between the CPU core's decode/control stage and instruction fetch; `pc` drives the fetch address directly.

## Interface
- `WORD_SIZE`, default 8: address width in bits.
- `STACK_DEPTH`, default 4: return-address stack entries, at least 1.
- `STEP_SIZE`, default 1: increment applied by STEP and pushed by CALL.
- `clock`  in  1: sole clock. All state changes on its rising edge.
- `reset_enable`  in  1: synchronous, active-high reset. Overrides every other input.
- `command`  in  3: operation for this cycle. Codes are in the Operation section.
- `value`  in  WORD_SIZE: jump/call target, or branch offset (two's complement).
- `clear_error`  in  1: clears `stack_error`.
- `pc`  out  WORD_SIZE: current address.
- `stack_count`  out  $clog2(STACK_DEPTH+1): number of valid entries.
- `stack_empty`  out  1: `stack_count == 0`.
- `stack_full`  out  1: `stack_count == STACK_DEPTH`.
- `stack_top`  out  WORD_SIZE: top entry; 0 when empty.
- `stack_error`  out  1: sticky; overflow or underflow has occurred.

## Operation
- Command codes:
  - HOLD=0: no change.
  - STEP=1: `pc <= pc + STEP_SIZE`.
  - BRANCH=2: `pc <= pc + signed(value)`.
  - JUMP=3: `pc <= value`.
  - CALL=4: push `pc + STEP_SIZE`, then `pc <= value`.
  - RETURN=5: `pc <=` top entry, then pop.
  - Codes 6 and 7 are treated as HOLD.
- Arithmetic is modulo 2^WORD_SIZE. Wrap-around in either direction is legal and raises no flag.
- CALL when `stack_full`:
  - `pc` and stack are unchanged.
  - `stack_error` is set.
- RETURN when `stack_empty`:
  - `pc` and stack are unchanged.
  - `stack_error` is set.
- `clear_error` and a new error in the same cycle: the error wins, so the flag stays 1.
- Stack entries are written only by CALL. Popped slots are not cleared. `stack_top` reads the entry at `stack_count-1`.
- Reset:
  - `pc`, `stack_count` and `stack_error` go to 0.
  - `stack_empty` = 1, `stack_full` = 0, `stack_top` = 0.
  - Applies mid-sequence regardless of `command`.

## Timing
- All outputs are registered or decoded from registers. A command sampled at edge N is visible after edge N; latency is 1 cycle.
- One command per cycle. Back-to-back CALL/RETURN on consecutive cycles is legal and needs no bubble.
- RETURN immediately after CALL returns the address pushed one cycle earlier.
- No combinational path from any input to any output.
- Reset has priority over `command` and `clear_error` in the same cycle.

## Structure
- Shared package `sequencer_pkg` holds:
  - the command code constants (HOLD, STEP, BRANCH, JUMP, CALL, RETURN);
  - the default `WORD_SIZE`.
- The core's `parameters.vh` continues to supply `WORD_SIZE` to users.
- One sub-module: `return_stack`, a LIFO of STACK_DEPTH×WORD_SIZE.
  - Inputs: `push`, `pop`, `push_data`.
  - Outputs: `top`, `count`, `full`, `empty`.
  - It ignores illegal push/pop itself. The sequencer raises the error flag.
- The top level owns the `pc` register, the next-pc mux and `stack_error`.

## Test plan
All scenarios use WORD_SIZE=8, STACK_DEPTH=4, STEP_SIZE=1.
- **Reset and step:** reset, then STEP ×3 → `pc` = 0,1,2,3. STEP at `pc`=0xFF → `pc`=0x00, `stack_error`=0.
- **Branch:**
  - At `pc`=0x10: BRANCH `value`=0xFC (−4) → 0x0C. BRANCH 0x05 → 0x11.
  - At `pc`=0x02: BRANCH 0xFC → 0xFE (wrap).
- **Call/return:** at `pc`=0x20, CALL 0x40 → `pc`=0x40, `stack_top`=0x21, `stack_count`=1. RETURN next cycle → `pc`=0x21, `stack_empty`=1.
- **Nested and overflow:** four CALLs to 0x50,0x60,0x70,0x80 → `stack_full`=1. Fifth CALL 0x90 → `pc` stays 0x80, `stack_error`=1. Four RETURNs unwind in LIFO order.
- **Underflow and error clear:**
  - RETURN when empty → `pc` unchanged, `stack_error`=1.
  - `clear_error` alone → 0.
  - `clear_error` together with an underflowing RETURN → stays 1.
- **Reset mid-operation:** with `stack_count`=2 and `pc`=0x33, assert `reset_enable` together with CALL 0x44 → `pc`=0, `stack_count`=0, `stack_error`=0, no push.
